dmem_responder: RTL and testbench



---
 rtl/dmem_pkg.sv | 21 ++
 rtl/dmem_array.sv | 33 +++
 rtl/dmem_responder.sv | 141 ++++++++++++++
 tb/tb_dmem_responder.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_pkg.sv
// Shared types and constants for the data-memory responder.
// Also holds the request error rule, so it is written down in exactly one place.
package dmem_pkg;

  localparam int WORD_W = 32;
  localparam int BE_W   = 4;
  localparam int CNT_W  = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_e;

  // Misaligned byte address, or word index past the end of the array.
  function automatic logic addr_err(input logic [WORD_W-1:0] addr,
                                    input int unsigned depth_words);
    return (addr[1:0] != 2'b00) || ({2'b00, addr[WORD_W-1:2]} >= depth_words);
  endfunction

endpackage

// File: rtl/dmem_array.sv
// Single-port word RAM with synchronous byte-enabled write and synchronous read.
// Contents are not reset.
module dmem_array
  import dmem_pkg::*;
#(
  parameter int DEPTH_WORDS = 1024,
  parameter int ADDR_W      = 10
) (
  input  logic              clk,
  input  logic              en,
  input  logic              we,
  input  logic [BE_W-1:0]   be,
  input  logic [ADDR_W-1:0] widx,
  input  logic [WORD_W-1:0] wdata,
  output logic [WORD_W-1:0] rdata
);

  logic [WORD_W-1:0] mem_q [DEPTH_WORDS];

  // rdata only updates on a load, so it holds the last load result afterwards.
  always_ff @(posedge clk) begin
    if (en) begin
      if (we) begin
        for (int i = 0; i < BE_W; i++) begin
          if (be[i]) mem_q[widx][8*i +: 8] <= wdata[8*i +: 8];
        end
      end else begin
        rdata <= mem_q[widx];
      end
    end
  end

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder: valid/ready request and response channels in front of
// dmem_array, with a configurable number of wait states before each access.
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int DEPTH_WORDS = 1024,
  parameter int WAIT_CYCLES = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [WORD_W-1:0] req_addr,
  input  logic [WORD_W-1:0] req_wdata,
  input  logic [BE_W-1:0]   req_be,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [WORD_W-1:0] resp_rdata,
  output logic              resp_err
);

  localparam int AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              acc_en;

  logic              we_q;
  logic              req_err_q;
  logic [AW-1:0]     widx_q;
  logic [WORD_W-1:0] wdata_q;
  logic [BE_W-1:0]   be_q;

  logic              load_ok_q;
  logic              resp_err_q;

  logic              a_we;
  logic              a_err;
  logic [AW-1:0]     a_widx;
  logic [WORD_W-1:0] a_wdata;
  logic [BE_W-1:0]   a_be;
  logic [WORD_W-1:0] ram_rdata;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    acc_en  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (req_valid) begin
          if (WAIT_CYCLES == 0) begin
            state_d = RESP;
            acc_en  = 1'b1;
          end else begin
            cnt_d   = CNT_W'(WAIT_CYCLES);
            state_d = WAIT;
          end
        end
      end
      WAIT: begin
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          state_d = RESP;
          acc_en  = 1'b1;
        end
      end
      RESP: begin
        if (resp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // With zero wait states the access happens on the acceptance edge itself,
  // so the live request fields feed the array instead of the captured copy.
  always_comb begin
    if (state_q == IDLE) begin
      a_we    = req_we;
      a_err   = addr_err(req_addr, DEPTH_WORDS);
      a_widx  = req_addr[AW+1:2];
      a_wdata = req_wdata;
      a_be    = req_be;
    end else begin
      a_we    = we_q;
      a_err   = req_err_q;
      a_widx  = widx_q;
      a_wdata = wdata_q;
      a_be    = be_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      load_ok_q  <= 1'b0;
      resp_err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (acc_en) begin
        load_ok_q  <= !a_we && !a_err;
        resp_err_q <= a_err;
      end else if ((state_q == RESP) && resp_ready) begin
        load_ok_q  <= 1'b0;
        resp_err_q <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if ((state_q == IDLE) && req_valid) begin
      we_q      <= req_we;
      req_err_q <= addr_err(req_addr, DEPTH_WORDS);
      widx_q    <= req_addr[AW+1:2];
      wdata_q   <= req_wdata;
      be_q      <= req_be;
    end
  end

  // A reset arriving on the access edge must leave the array untouched.
  dmem_array #(
    .DEPTH_WORDS (DEPTH_WORDS),
    .ADDR_W      (AW)
  ) u_array (
    .clk   (clk),
    .en    (acc_en && !a_err && !rst),
    .we    (a_we),
    .be    (a_be),
    .widx  (a_widx),
    .wdata (a_wdata),
    .rdata (ram_rdata)
  );

  assign req_ready  = (state_q == IDLE) && !rst;
  assign resp_valid = (state_q == RESP) && !rst;
  assign resp_rdata = (load_ok_q && !rst) ? ram_rdata : '0;
  assign resp_err   = resp_err_q && !rst;

endmodule

// File: tb/tb_dmem_responder.sv
// Self-checking bench: a two-wait-state instance and a zero-wait instance
// share stimulus, each checked against a word-array reference model.
module tb_dmem_responder;

  localparam int DEPTH = 64;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_we = 1'b0;
  logic [31:0] req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic [3:0]  req_be = '0;
  logic        resp_ready = 1'b0;
  bit          sel = 1'b0;

  logic        rrdy_a, rrdy_b, rvalid_a, rvalid_b, err_a, err_b;
  logic [31:0] rdata_a, rdata_b;
  logic        rrdy, rvalid, rerr;
  logic [31:0] rdata;

  int n_vec = 0;
  int n_err = 0;

  logic [31:0] mdl [2][DEPTH];

  always #5 clk = ~clk;

  dmem_responder #(.DEPTH_WORDS(DEPTH), .WAIT_CYCLES(2)) u_dut2 (
    .clk(clk), .rst(rst), .req_valid(req_valid && !sel), .req_ready(rrdy_a),
    .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata), .req_be(req_be),
    .resp_valid(rvalid_a), .resp_ready(resp_ready), .resp_rdata(rdata_a), .resp_err(err_a));

  dmem_responder #(.DEPTH_WORDS(DEPTH), .WAIT_CYCLES(0)) u_dut0 (
    .clk(clk), .rst(rst), .req_valid(req_valid && sel), .req_ready(rrdy_b),
    .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata), .req_be(req_be),
    .resp_valid(rvalid_b), .resp_ready(resp_ready), .resp_rdata(rdata_b), .resp_err(err_b));

  assign rrdy   = sel ? rrdy_b   : rrdy_a;
  assign rvalid = sel ? rvalid_b : rvalid_a;
  assign rdata  = sel ? rdata_b  : rdata_a;
  assign rerr   = sel ? err_b    : err_a;

  function automatic int exp_lat();
    return sel ? 1 : 3;
  endfunction

  // Reference: error rule on the byte address, byte-merge for stores, word read for loads.
  function automatic void model_access(input bit we, input logic [31:0] addr, input logic [31:0] wdata,
                                       input logic [3:0] be, output logic [31:0] er, output logic ee);
    int w;
    ee = (addr % 4 != 0) || ((addr / 4) >= DEPTH);
    er = '0;
    if (!ee) begin
      w = int'(addr / 4);
      if (we) begin
        for (int i = 0; i < 4; i++) if (be[i]) mdl[sel][w][8*i +: 8] = wdata[8*i +: 8];
      end else begin
        er = mdl[sel][w];
      end
    end
  endfunction

  task automatic txn(input bit we, input logic [31:0] addr, input logic [31:0] wdata, input logic [3:0] be,
                     output logic [31:0] rd, output logic er, output int lat, output int waited);
    @(negedge clk);
    req_valid = 1'b1; req_we = we; req_addr = addr; req_wdata = wdata; req_be = be; resp_ready = 1'b1;
    waited = 0;
    while (!rrdy && waited < 40) begin @(negedge clk); waited++; end
    @(posedge clk); #1;
    req_valid = 1'b0; req_addr = $urandom; req_wdata = $urandom; req_be = 4'($urandom);
    lat = 0;
    do begin @(negedge clk); lat++; end while (!rvalid && lat < 40);
    rd = rdata; er = rerr;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    n_vec++; if ({rrdy_a, rrdy_b, rvalid_a, rvalid_b} !== 4'b0000) begin n_err++;
      $display("FAIL reset_held: got rdy/valid %b want 0000", {rrdy_a, rrdy_b, rvalid_a, rvalid_b}); end
    rst = 1'b0;
    @(negedge clk);
    n_vec++; if ({rrdy_a, rrdy_b, rvalid_a, rvalid_b, err_a, err_b} !== 6'b110000) begin n_err++;
      $display("FAIL reset_release: got %b want 110000", {rrdy_a, rrdy_b, rvalid_a, rvalid_b, err_a, err_b}); end
    n_vec++; if ((rdata_a | rdata_b) !== 32'h0) begin n_err++;
      $display("FAIL reset_rdata: got %h want 00000000", rdata_a | rdata_b); end
  endtask

  task automatic init_mem();
    logic [31:0] rd; logic er; int lat, wt;
    for (int s = 0; s < 2; s++) begin
      sel = s[0];
      for (int w = 0; w < DEPTH; w++) begin
        txn(1'b1, 32'(w * 4), 32'h0, 4'hF, rd, er, lat, wt);
        mdl[s][w] = 32'h0;
      end
    end
    sel = 1'b0;
  endtask

  task automatic test_store_load();
    logic [31:0] rd, er_d; logic er, ee; int lat, wt;
    sel = 1'b0;
    model_access(1'b1, 32'h10, 32'hDEADBEEF, 4'hF, er_d, ee);
    txn(1'b1, 32'h10, 32'hDEADBEEF, 4'hF, rd, er, lat, wt);
    n_vec++; if (lat !== 3) begin n_err++; $display("FAIL store_latency: got %0d want 3", lat); end
    n_vec++; if ({er, rd} !== {1'b0, 32'h0}) begin n_err++; $display("FAIL store_resp: got err=%b rdata=%h want err=0 rdata=0", er, rd); end
    model_access(1'b0, 32'h10, 32'h0, 4'h0, er_d, ee);
    txn(1'b0, 32'h10, 32'h0, 4'h0, rd, er, lat, wt);
    n_vec++; if (lat !== 3) begin n_err++; $display("FAIL load_latency: got %0d want 3", lat); end
    n_vec++; if (rd !== 32'hDEADBEEF || er !== 1'b0) begin n_err++; $display("FAIL load_full: got %h err=%b want deadbeef err=0", rd, er); end
    model_access(1'b1, 32'h10, 32'h000000AA, 4'b0001, er_d, ee);
    txn(1'b1, 32'h10, 32'h000000AA, 4'b0001, rd, er, lat, wt);
    model_access(1'b0, 32'h10, 32'h0, 4'h0, er_d, ee);
    txn(1'b0, 32'h10, 32'h0, 4'hF, rd, er, lat, wt);
    n_vec++; if (rd !== 32'hDEADBEAA || rd !== er_d) begin n_err++; $display("FAIL byte_merge: got %h want deadbeaa", rd); end
  endtask

  task automatic test_errors();
    logic [31:0] rd, er_d; logic er, ee; int lat, wt;
    sel = 1'b0;
    model_access(1'b1, 32'(4 * (DEPTH - 1)), 32'hCAFE0123, 4'hF, er_d, ee);
    txn(1'b1, 32'(4 * (DEPTH - 1)), 32'hCAFE0123, 4'hF, rd, er, lat, wt);
    n_vec++; if (er !== 1'b0) begin n_err++; $display("FAIL top_word_ok: got err=%b want 0", er); end
    txn(1'b0, 32'h12, 32'h0, 4'hF, rd, er, lat, wt);
    n_vec++; if ({er, rd} !== {1'b1, 32'h0}) begin n_err++; $display("FAIL misaligned: got err=%b rdata=%h want err=1 rdata=0", er, rd); end
    txn(1'b1, 32'(4 * DEPTH), 32'h55555555, 4'hF, rd, er, lat, wt);
    n_vec++; if ({er, rd} !== {1'b1, 32'h0}) begin n_err++; $display("FAIL out_of_range: got err=%b rdata=%h want err=1 rdata=0", er, rd); end
    model_access(1'b0, 32'(4 * (DEPTH - 1)), 32'h0, 4'h0, er_d, ee);
    txn(1'b0, 32'(4 * (DEPTH - 1)), 32'h0, 4'hF, rd, er, lat, wt);
    n_vec++; if (rd !== 32'hCAFE0123 || er !== 1'b0) begin n_err++; $display("FAIL top_word_kept: got %h err=%b want cafe0123 err=0", rd, er); end
  endtask

  task automatic test_backpressure();
    logic [31:0] rd, er_d, held, d; logic er, ee; int lat, wt;
    sel = 1'b0;
    d = $urandom;
    model_access(1'b0, 32'h10, 32'h0, 4'h0, er_d, ee);
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b0; req_addr = 32'h10; req_be = 4'h0; resp_ready = 1'b0;
    wt = 0; while (!rrdy && wt < 40) begin @(negedge clk); wt++; end
    @(posedge clk); #1;
    req_we = 1'b1; req_addr = 32'h14; req_wdata = d; req_be = 4'hF;
    lat = 0; do begin @(negedge clk); lat++; end while (!rvalid && lat < 40);
    n_vec++; if (lat !== 3) begin n_err++; $display("FAIL bp_latency: got %0d want 3", lat); end
    n_vec++; if (rdata !== er_d || rerr !== 1'b0) begin n_err++; $display("FAIL bp_rdata: got %h err=%b want %h err=0", rdata, rerr, er_d); end
    held = rdata;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      n_vec++; if ({rvalid, rrdy, rerr, rdata} !== {3'b100, held}) begin n_err++;
        $display("FAIL bp_hold: got valid=%b ready=%b err=%b rdata=%h want 1 0 0 %h", rvalid, rrdy, rerr, rdata, held); end
    end
    resp_ready = 1'b1;
    @(negedge clk);
    n_vec++; if ({rvalid, rrdy} !== 2'b01) begin n_err++; $display("FAIL bp_release: got valid=%b ready=%b want 0 1", rvalid, rrdy); end
    @(posedge clk); #1;
    req_valid = 1'b0;
    model_access(1'b1, 32'h14, d, 4'hF, er_d, ee);
    lat = 0; do begin @(negedge clk); lat++; end while (!rvalid && lat < 40);
    n_vec++; if (lat !== 3 || rerr !== 1'b0) begin n_err++; $display("FAIL bp_store: got lat=%0d err=%b want 3 0", lat, rerr); end
    @(posedge clk); #1;
    model_access(1'b0, 32'h14, 32'h0, 4'h0, er_d, ee);
    txn(1'b0, 32'h14, 32'h0, 4'h0, rd, er, lat, wt);
    n_vec++; if (rd !== er_d) begin n_err++; $display("FAIL bp_store_data: got %h want %h", rd, er_d); end
  endtask

  task automatic test_reset_mid();
    logic [31:0] rd, er_d; logic er, ee; int lat, wt;
    sel = 1'b0;
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; req_addr = 32'h20; req_wdata = 32'h12345678; req_be = 4'hF; resp_ready = 1'b1;
    wt = 0; while (!rrdy && wt < 40) begin @(negedge clk); wt++; end
    @(posedge clk); #1 req_valid = 1'b0;
    @(negedge clk); rst = 1'b1;
    #1;
    n_vec++; if (rrdy !== 1'b0) begin n_err++; $display("FAIL rst_wait_ready: got %b want 0", rrdy); end
    @(negedge clk); rst = 1'b0;
    #1;
    n_vec++; if ({rrdy, rvalid} !== 2'b10) begin n_err++; $display("FAIL rst_wait_after: got ready=%b valid=%b want 1 0", rrdy, rvalid); end
    model_access(1'b0, 32'h20, 32'h0, 4'h0, er_d, ee);
    txn(1'b0, 32'h20, 32'h0, 4'hF, rd, er, lat, wt);
    n_vec++; if (rd !== er_d) begin n_err++; $display("FAIL rst_wait_discard: got %h want %h", rd, er_d); end
    // Store reaches RESP, then reset drops the response; the write stays.
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; req_addr = 32'h24; req_wdata = 32'hA5A5A5A5; req_be = 4'hF; resp_ready = 1'b0;
    wt = 0; while (!rrdy && wt < 40) begin @(negedge clk); wt++; end
    @(posedge clk); #1 req_valid = 1'b0;
    lat = 0; do begin @(negedge clk); lat++; end while (!rvalid && lat < 40);
    rst = 1'b1;
    @(negedge clk); rst = 1'b0; resp_ready = 1'b1;
    n_vec++; if (rvalid !== 1'b0) begin n_err++; $display("FAIL rst_resp_drop: got valid=%b want 0", rvalid); end
    model_access(1'b1, 32'h24, 32'hA5A5A5A5, 4'hF, er_d, ee);
    model_access(1'b0, 32'h24, 32'h0, 4'h0, er_d, ee);
    txn(1'b0, 32'h24, 32'h0, 4'hF, rd, er, lat, wt);
    n_vec++; if (rd !== er_d) begin n_err++; $display("FAIL rst_resp_commit: got %h want %h", rd, er_d); end
  endtask

  task automatic test_zero_wait();
    logic [31:0] rd, er_d, d; logic er, ee; int lat, wt;
    sel = 1'b1;
    d = $urandom;
    model_access(1'b1, 32'h40, d, 4'hF, er_d, ee);
    txn(1'b1, 32'h40, d, 4'hF, rd, er, lat, wt);
    n_vec++; if (lat !== 1) begin n_err++; $display("FAIL zw_store_latency: got %0d want 1", lat); end
    model_access(1'b0, 32'h40, 32'h0, 4'h0, er_d, ee);
    txn(1'b0, 32'h40, 32'h0, 4'hF, rd, er, lat, wt);
    n_vec++; if (lat !== 1 || wt !== 0) begin n_err++; $display("FAIL zw_b2b: got lat=%0d waited=%0d want 1 0", lat, wt); end
    n_vec++; if (rd !== er_d || er !== 1'b0) begin n_err++; $display("FAIL zw_load: got %h err=%b want %h err=0", rd, er, er_d); end
    sel = 1'b0;
  endtask

  task automatic test_random();
    logic [31:0] rd, er_d, addr, d; logic er, ee; int lat, wt, w, lo; bit we; logic [3:0] be;
    for (int s = 0; s < 2; s++) begin
      sel = s[0];
      for (int k = 0; k < 30; k++) begin
        w  = $urandom_range(0, DEPTH + 3);
        lo = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : 0;
        addr = 32'(w * 4 + lo);
        if ($urandom_range(0, 15) == 0) addr = $urandom;
        we = 1'($urandom); d = $urandom; be = 4'($urandom);
        model_access(we, addr, d, be, er_d, ee);
        txn(we, addr, d, be, rd, er, lat, wt);
        n_vec++; if (lat !== exp_lat()) begin n_err++; $display("FAIL rnd_latency: got %0d want %0d addr=%h", lat, exp_lat(), addr); end
        n_vec++; if (er !== ee) begin n_err++; $display("FAIL rnd_err: got %b want %b addr=%h", er, ee, addr); end
        n_vec++; if (rd !== er_d) begin n_err++; $display("FAIL rnd_rdata: got %h want %h addr=%h we=%b", rd, er_d, addr, we); end
      end
    end
    sel = 1'b0;
  endtask

  initial begin
    test_reset();
    init_mem();
    test_store_load();
    test_errors();
    test_backpressure();
    test_reset_mid();
    test_zero_wait();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
